// File: rtl/barramento_pkg.sv
// Shared types for the barramento bus sequencer: port-count defaults, FSM states, and the
// queued transfer command.
package barramento_pkg;

    localparam int unsigned N_PORTS_DEF = 6;
    localparam int unsigned IDX_W_DEF   = 3;

    typedef enum logic [1:0] {
        StIdle,
        StDrive,
        StLoad,
        StTurn
    } state_e;

    typedef struct packed {
        logic [IDX_W_DEF-1:0] src;
        logic [IDX_W_DEF-1:0] dst;
    } cmd_t;

    // Indices at or beyond the port count shift out and yield an all-zero vector.
    function automatic logic [N_PORTS_DEF-1:0] onehot(input logic [IDX_W_DEF-1:0] idx);
        onehot = {{(N_PORTS_DEF - 1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/fila_comandos.sv
// Show-ahead synchronous command FIFO. The pointers carry one extra wrap bit so that full and
// empty can be told apart when the indices match.
module fila_comandos #(
    parameter int unsigned Width = 6,
    parameter int unsigned Depth = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [Width-1:0] din_i,
    input  logic             pop_i,
    output logic [Width-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PtrW = $clog2(Depth);

    if ((Depth < 2) || ((Depth & (Depth - 1)) != 0)) begin : g_bad_depth
        $error("fila_comandos: Depth must be a power of two and at least 2");
    end

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW:0]    wr_ptr_q, wr_ptr_d;
    logic [PtrW:0]    rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    assign full_o  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                     (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign dout_o  = mem_q[rd_ptr_q[PtrW-1:0]];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset; emptiness is tracked by the pointers alone.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q[PtrW-1:0]] <= din_i;
        end
    end

endmodule

// File: rtl/barramento_controlador.sv
// Sequences queued source->destination transfers on the shared tristate bus as
// DRIVE, LOAD, TURN steps, with TURN as the dead cycle between bus drivers.
module barramento_controlador
    import barramento_pkg::*;
#(
    parameter int unsigned N_PORTS    = N_PORTS_DEF,
    parameter int unsigned IDX_W      = IDX_W_DEF,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [IDX_W-1:0]   req_src,
    input  logic [IDX_W-1:0]   req_dst,
    output logic [N_PORTS-1:0] ctrl,
    output logic [N_PORTS-1:0] load,
    output logic               busy,
    output logic               done,
    output logic               err
);

    // cmd_t and onehot() are sized by the package, so the port geometry must match it.
    if ((N_PORTS != N_PORTS_DEF) || (IDX_W != IDX_W_DEF)) begin : g_bad_cfg
        $error("barramento_controlador: N_PORTS/IDX_W must match barramento_pkg");
    end

    state_e             state_q, state_d;
    cmd_t               cmd_q, cmd_d;
    cmd_t               req_cmd, fifo_dout;
    logic [N_PORTS-1:0] ctrl_q, ctrl_d;
    logic [N_PORTS-1:0] load_q, load_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               fifo_full, fifo_empty, fifo_pop, fifo_push;
    logic               cmd_ok, accept;

    assign req_cmd   = {req_src, req_dst};
    assign req_ready = ~fifo_full;
    assign accept    = req_valid & req_ready;
    assign cmd_ok    = (req_src != req_dst) && (32'(req_src) < N_PORTS) &&
                       (32'(req_dst) < N_PORTS);
    // Rejected commands are still consumed by the handshake, just never queued.
    assign fifo_push = accept & cmd_ok;

    fila_comandos #(
        .Width ($bits(cmd_t)),
        .Depth (FIFO_DEPTH)
    ) u_fila (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (fifo_push),
        .din_i   (req_cmd),
        .pop_i   (fifo_pop),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        fifo_pop = 1'b0;
        unique case (state_q)
            StIdle, StTurn: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    cmd_d    = fifo_dout;
                    state_d  = StDrive;
                end else begin
                    state_d = StIdle;
                end
            end
            StDrive: state_d = StLoad;
            StLoad:  state_d = StTurn;
            default: state_d = StIdle;
        endcase

        // Outputs are decoded from the next state so they leave the flops glitch-free.
        ctrl_d = '0;
        load_d = '0;
        unique case (state_d)
            StDrive: ctrl_d = onehot(cmd_d.src);
            StLoad: begin
                ctrl_d = onehot(cmd_d.src);
                load_d = onehot(cmd_d.dst);
            end
            default: ;
        endcase
        done_d = (state_d == StTurn);
        err_d  = accept & ~cmd_ok;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cmd_q   <= '0;
            ctrl_q  <= '0;
            load_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            ctrl_q  <= ctrl_d;
            load_q  <= load_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign ctrl = ctrl_q;
    assign load = load_q;
    assign done = done_q;
    assign err  = err_q;
    assign busy = (state_q != StIdle) | ~fifo_empty;

endmodule

// File: tb/tb_barramento_controlador.sv
// Directed vectors and sequences plus a randomized scoreboard run for barramento_controlador.
module tb_barramento_controlador;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic [2:0] req_src, req_dst;
    logic [5:0] ctrl, load;
    logic       busy, done, err;

    int n_tests = 0;
    int n_fail  = 0;

    barramento_controlador #(
        .N_PORTS    (6),
        .IDX_W      (3),
        .FIFO_DEPTH (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_src   (req_src),
        .req_dst   (req_dst),
        .ctrl      (ctrl),
        .load      (load),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] src;
        logic [2:0] dst;
        logic [5:0] exp_ctrl;
        logic [5:0] exp_load;
        logic       exp_err;
    } vec_t;

    vec_t vecs[8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Expected {ctrl, load, done, err, busy} in cycle c after an isolated accept at cycle 0.
    function automatic logic [14:0] vec_exp(input vec_t t, input int c);
        if (t.exp_err) begin
            return (c == 1) ? 15'd2 : 15'd0;
        end
        case (c)
            1:       return 15'd1;
            2:       return {t.exp_ctrl, 6'b0, 3'b001};
            3:       return {t.exp_ctrl, t.exp_load, 3'b001};
            4:       return {12'b0, 3'b101};
            default: return 15'd0;
        endcase
    endfunction

    // Expected {ctrl, load, done} for four back-to-back commands 0->5, 2->4, 5->0, 3->1.
    function automatic logic [12:0] b2b_exp(input int k);
        case (k)
            2:              return {6'b000001, 6'b000000, 1'b0};
            3:              return {6'b000001, 6'b100000, 1'b0};
            5:              return {6'b000100, 6'b000000, 1'b0};
            6:              return {6'b000100, 6'b010000, 1'b0};
            8:              return {6'b100000, 6'b000000, 1'b0};
            9:              return {6'b100000, 6'b000001, 1'b0};
            11:             return {6'b001000, 6'b000000, 1'b0};
            12:             return {6'b001000, 6'b000010, 1'b0};
            4, 7, 10, 13:   return {12'b0, 1'b1};
            default:        return 13'b0;
        endcase
    endfunction

    // Random-phase state
    logic [11:0] sb[$];
    logic [5:0]  prev_ctrl;
    logic        err_exp;
    logic        pending;
    int          n_acc, n_valid, done_cnt;

    task automatic rnd_cycle(input bit allow_new);
        logic        ok;
        logic        bad;
        logic [5:0]  one;
        logic [11:0] e;
        one = 6'b000001;
        if (allow_new && !pending && ($urandom_range(0, 1) == 1)) begin
            pending = 1'b1;
            req_src = 3'($urandom_range(0, 6));
            req_dst = 3'($urandom_range(0, 6));
        end
        req_valid = pending;

        ok = ($countones(ctrl) <= 1) && ($countones(load) <= 1) &&
             !((load != 6'b0) && (ctrl == 6'b0)) &&
             !((ctrl != 6'b0) && (prev_ctrl != 6'b0) && (ctrl != prev_ctrl));
        check("rnd_invariants", 32'(ok), 32'd1);
        if (load != 6'b0) begin
            if (sb.size() == 0) begin
                check("rnd_unexpected_load", {20'b0, ctrl, load}, 32'd0);
            end else begin
                e = sb.pop_front();
                check("rnd_order", {20'b0, ctrl, load}, {20'b0, e});
            end
        end
        check("rnd_err", 32'(err), 32'(err_exp));
        if (done) done_cnt++;
        prev_ctrl = ctrl;

        err_exp = 1'b0;
        if (req_valid && req_ready) begin
            bad = (req_src == req_dst) || (req_src > 3'd5) || (req_dst > 3'd5);
            if (bad) begin
                err_exp = 1'b1;
            end else begin
                sb.push_back({one << req_src, one << req_dst});
                n_valid++;
            end
            n_acc++;
            pending = 1'b0;
        end
        tick();
    endtask

    initial begin
        logic [2:0] fs_src[7];
        logic [2:0] fs_dst[7];
        logic [2:0] bb_src[4];
        logic [2:0] bb_dst[4];
        logic [9:0] exp_ready;
        int         i;
        int         dcnt;
        bit         acc;

        vecs[0] = '{3'd1, 3'd3, 6'b000010, 6'b001000, 1'b0};
        vecs[1] = '{3'd0, 3'd5, 6'b000001, 6'b100000, 1'b0};
        vecs[2] = '{3'd5, 3'd0, 6'b100000, 6'b000001, 1'b0};
        vecs[3] = '{3'd4, 3'd2, 6'b010000, 6'b000100, 1'b0};
        vecs[4] = '{3'd2, 3'd2, 6'b000000, 6'b000000, 1'b1};
        vecs[5] = '{3'd7, 3'd0, 6'b000000, 6'b000000, 1'b1};
        vecs[6] = '{3'd3, 3'd6, 6'b000000, 6'b000000, 1'b1};
        vecs[7] = '{3'd6, 3'd7, 6'b000000, 6'b000000, 1'b1};
        bb_src = '{3'd0, 3'd2, 3'd5, 3'd3};
        bb_dst = '{3'd5, 3'd4, 3'd0, 3'd1};
        fs_src = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd1};
        fs_dst = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0, 3'd4};
        exp_ready = 10'b0100111111;

        rst = 1'b1;
        req_valid = 1'b0;
        req_src = 3'd0;
        req_dst = 3'd0;
        tick();
        tick();
        rst = 1'b0;
        check("reset_outputs", {17'b0, ctrl, load, done, err, busy}, 32'd0);
        check("reset_ready", 32'(req_ready), 32'd1);

        // Isolated transfers, valid and rejected
        for (int v = 0; v < 8; v++) begin
            req_valid = 1'b1;
            req_src   = vecs[v].src;
            req_dst   = vecs[v].dst;
            check($sformatf("vec%0d_ready", v), 32'(req_ready), 32'd1);
            tick();
            req_valid = 1'b0;
            for (int c = 1; c <= 5; c++) begin
                check($sformatf("vec%0d_cycle%0d", v, c),
                      {17'b0, ctrl, load, done, err, busy}, {17'b0, vec_exp(vecs[v], c)});
                tick();
            end
        end

        // Four back-to-back commands
        dcnt = 0;
        for (int k = 0; k <= 14; k++) begin
            if (k < 4) begin
                req_valid = 1'b1;
                req_src   = bb_src[k];
                req_dst   = bb_dst[k];
                check($sformatf("b2b_ready_%0d", k), 32'(req_ready), 32'd1);
            end else begin
                req_valid = 1'b0;
            end
            check($sformatf("b2b_cycle%0d", k), {19'b0, ctrl, load, done},
                  {19'b0, b2b_exp(k)});
            if (done) dcnt++;
            if (k == 14) check("b2b_idle", 32'(busy), 32'd0);
            tick();
        end
        check("b2b_done_count", 32'(dcnt), 32'd4);

        // Fill the queue until it pushes back, then let the held command drain in behind
        i = 0;
        dcnt = 0;
        for (int k = 0; k <= 23; k++) begin
            if (i < 7) begin
                req_valid = 1'b1;
                req_src   = fs_src[i];
                req_dst   = fs_dst[i];
            end else begin
                req_valid = 1'b0;
            end
            if (k < 10) check($sformatf("full_ready_%0d", k), 32'(req_ready), 32'(exp_ready[k]));
            if (k == 20) check("full_7th_ctrl", {26'b0, ctrl}, 32'b000010);
            if (k == 21) check("full_7th_load", {26'b0, load}, 32'b010000);
            if (k == 23) check("full_idle", 32'(busy), 32'd0);
            if (done) dcnt++;
            acc = req_valid && req_ready;
            tick();
            if (acc) i++;
        end
        check("full_accepted", 32'(i), 32'd7);
        check("full_done_count", 32'(dcnt), 32'd7);

        // Reset while the first of three commands is in LOAD
        for (int k = 0; k <= 10; k++) begin
            rst = 1'b0;
            if (k < 3) begin
                req_valid = 1'b1;
                req_src   = fs_src[2 * k % 6];
                req_dst   = fs_dst[2 * k % 6];
            end else begin
                req_valid = 1'b0;
            end
            if (k == 3) begin
                check("rst_in_load", {20'b0, ctrl, load}, {20'b0, 6'b000001, 6'b000010});
                rst = 1'b1;
            end
            if (k >= 4) begin
                check($sformatf("rst_quiet_%0d", k), {17'b0, ctrl, load, done, err, busy}, 32'd0);
            end
            if (k == 4) check("rst_ready", 32'(req_ready), 32'd1);
            tick();
        end
        rst = 1'b0;

        // Randomized traffic with backpressure
        prev_ctrl = 6'b0;
        err_exp   = 1'b0;
        pending   = 1'b0;
        n_acc     = 0;
        n_valid   = 0;
        done_cnt  = 0;
        for (int cyc = 0; cyc < 20000 && n_acc < 1000; cyc++) begin
            rnd_cycle(1'b1);
        end
        check("rnd_accepted", 32'(n_acc), 32'd1000);
        pending   = 1'b0;
        req_valid = 1'b0;
        for (int j = 0; j < 300 && (busy || err_exp); j++) begin
            rnd_cycle(1'b0);
        end
        check("rnd_drained", 32'(busy), 32'd0);
        check("rnd_done_count", 32'(done_cnt), 32'(n_valid));
        check("rnd_sb_empty", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
